// File: rtl/imm_gen_buf_if.sv
// Handshake bundle between IR capture, the immediate buffer and the ALU B-operand mux.
// Both sides use valid/ready: a transfer happens on a rising edge where valid and ready are both 1;
// valid and its payload hold until accepted, and ready never depends combinationally on valid.
interface imm_gen_buf_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [31:0]      in_instr;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    logic [TAG_W-1:0] out_tag;
    logic             out_err;

    modport slave (
        input  flush, in_valid, in_op, in_instr, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_tag, out_err
    );

    modport master (
        output flush, in_valid, in_op, in_instr, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_tag, out_err
    );
endinterface

// File: rtl/imm_gen_buf.sv
// RISC-V immediate decoder (I/S/B/U/J/Z/SHAMT/AUTO) feeding a DEPTH-entry circular buffer.
// dbg_count exposes the occupancy register for checkers.
module imm_gen_buf #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    imm_gen_buf_if.slave           bus,
    output logic [$clog2(DEPTH):0] dbg_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    localparam logic [2:0] OP_I     = 3'd0;
    localparam logic [2:0] OP_S     = 3'd1;
    localparam logic [2:0] OP_B     = 3'd2;
    localparam logic [2:0] OP_U     = 3'd3;
    localparam logic [2:0] OP_J     = 3'd4;
    localparam logic [2:0] OP_Z     = 3'd5;
    localparam logic [2:0] OP_SHAMT = 3'd6;
    localparam logic [2:0] OP_AUTO  = 3'd7;

    if (!(XLEN == 32 || XLEN == 64)) begin : g_bad_xlen
        $error("imm_gen_buf: XLEN must be 32 or 64");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("imm_gen_buf: DEPTH must be a power of two >= 2");
    end

    logic [2:0]      fmt;
    logic [XLEN-1:0] dec_imm;
    logic            dec_err;
    logic [31:0]     ins;

    assign ins = bus.in_instr;

    // AUTO resolves to a concrete format; an unknown opcode leaves fmt at AUTO, which decodes to zero.
    always_comb begin
        fmt     = bus.in_op;
        dec_err = 1'b0;
        if (bus.in_op == OP_AUTO) begin
            case (ins[6:0])
                7'b0010011, 7'b0000011, 7'b1100111: fmt = OP_I;
                7'b0100011:                         fmt = OP_S;
                7'b1100011:                         fmt = OP_B;
                7'b0110111, 7'b0010111:             fmt = OP_U;
                7'b1101111:                         fmt = OP_J;
                7'b1110011:                         fmt = ins[14] ? OP_Z : OP_I;
                default:                            dec_err = 1'b1;
            endcase
        end

        dec_imm = {XLEN{ins[31]}};
        case (fmt)
            OP_I: dec_imm[11:0] = ins[31:20];
            OP_S: dec_imm[11:0] = {ins[31:25], ins[11:7]};
            OP_B: dec_imm[12:0] = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            OP_U: dec_imm[31:0] = {ins[31:12], 12'b0};
            OP_J: dec_imm[20:0] = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            OP_Z: begin
                dec_imm      = '0;
                dec_imm[4:0] = ins[19:15];
            end
            OP_SHAMT: begin
                dec_imm = '0;
                if (XLEN == 64) dec_imm[5:0] = ins[25:20];
                else            dec_imm[4:0] = ins[24:20];
            end
            default: dec_imm = '0;
        endcase
    end

    logic [XLEN-1:0]  imm_mem [DEPTH];
    logic [TAG_W-1:0] tag_mem [DEPTH];
    logic             err_mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;
    logic             zero_head;
    logic             push, pop;

    assign bus.in_ready  = (count != FULL);
    assign bus.out_valid = (count != '0);
    assign push          = bus.in_valid & bus.in_ready;
    assign pop           = bus.out_valid & bus.out_ready;
    assign dbg_count     = count;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            zero_head <= 1'b1;
        end else if (bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr    <= wr_ptr + 1'b1;
                zero_head <= 1'b0;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage has no reset; a dropped push must not overwrite an entry either.
    always_ff @(posedge clk) begin
        if (push && !bus.flush && !rst) begin
            imm_mem[wr_ptr] <= dec_imm;
            tag_mem[wr_ptr] <= bus.in_tag;
            err_mem[wr_ptr] <= dec_err;
        end
    end

    // Until the first push after reset, the head reads as zero instead of uninitialised storage.
    assign bus.out_imm = zero_head ? '0 : imm_mem[rd_ptr];
    assign bus.out_tag = zero_head ? '0 : tag_mem[rd_ptr];
    assign bus.out_err = zero_head ? 1'b0 : err_mem[rd_ptr];
endmodule

// File: tb/tb_imm_gen_buf.sv
// Directed bench for imm_gen_buf: decoder vectors at XLEN 32/64 plus buffer ordering, flush and reset.
module tb_imm_gen_buf;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    imm_gen_buf_if #(.XLEN(32), .TAG_W(4)) b32();
    imm_gen_buf_if #(.XLEN(64), .TAG_W(4)) b64();
    logic [1:0] cnt32, cnt64;

    imm_gen_buf #(.XLEN(32), .TAG_W(4), .DEPTH(2)) u32 (
        .clk(clk), .rst(rst), .bus(b32.slave), .dbg_count(cnt32)
    );
    imm_gen_buf #(.XLEN(64), .TAG_W(4), .DEPTH(2)) u64 (
        .clk(clk), .rst(rst), .bus(b64.slave), .dbg_count(cnt64)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_pop   = 0;
    logic [3:0] exp_q[$];

    task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // One clock of the 32-bit buffer against a queue model of the handshake rules.
    task automatic cycle32();
        int sz;
        sz = exp_q.size();
        check_eq("count", 64'(cnt32), 64'(sz));
        check_eq("in_ready", 64'(b32.in_ready), 64'(sz != 2));
        check_eq("out_valid", 64'(b32.out_valid), 64'(sz != 0));
        if (rst || b32.flush) begin
            exp_q.delete();
        end else begin
            if (b32.out_ready && sz != 0) begin
                check_eq("order_tag", 64'(b32.out_tag), 64'(exp_q.pop_front()));
                n_pop++;
            end
            if (b32.in_valid && sz != 2) exp_q.push_back(b32.in_tag);
        end
        @(negedge clk);
    endtask

    task automatic xfer32(input string name, input logic [2:0] op, input logic [31:0] instr,
                          input logic [3:0] tag, input logic [31:0] exp_imm, input logic exp_err);
        b32.in_op = op; b32.in_instr = instr; b32.in_tag = tag; b32.in_valid = 1'b1;
        check_eq({name, "_pre_valid"}, 64'(b32.out_valid), 64'd0);
        @(negedge clk);
        b32.in_valid = 1'b0;
        check_eq({name, "_valid"}, 64'(b32.out_valid), 64'd1);
        check_eq({name, "_imm"}, 64'(b32.out_imm), 64'(exp_imm));
        check_eq({name, "_err"}, 64'(b32.out_err), 64'(exp_err));
        check_eq({name, "_tag"}, 64'(b32.out_tag), 64'(tag));
        b32.out_ready = 1'b1;
        @(negedge clk);
        b32.out_ready = 1'b0;
        check_eq({name, "_drained"}, 64'(b32.out_valid), 64'd0);
    endtask

    task automatic xfer64(input string name, input logic [2:0] op, input logic [31:0] instr,
                          input logic [63:0] exp_imm);
        b64.in_op = op; b64.in_instr = instr; b64.in_tag = 4'd3; b64.in_valid = 1'b1;
        @(negedge clk);
        b64.in_valid = 1'b0;
        check_eq({name, "_valid"}, 64'(b64.out_valid), 64'd1);
        check_eq({name, "_imm"}, b64.out_imm, exp_imm);
        check_eq({name, "_err"}, 64'(b64.out_err), 64'd0);
        b64.out_ready = 1'b1;
        @(negedge clk);
        b64.out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        b32.flush = 0; b32.in_valid = 0; b32.in_op = 0; b32.in_instr = 0; b32.in_tag = 0; b32.out_ready = 0;
        b64.flush = 0; b64.in_valid = 0; b64.in_op = 0; b64.in_instr = 0; b64.in_tag = 0; b64.out_ready = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_eq("rst_in_ready", 64'(b32.in_ready), 64'd1);
        check_eq("rst_out_valid", 64'(b32.out_valid), 64'd0);
        check_eq("rst_out_imm", 64'(b32.out_imm), 64'd0);
        check_eq("rst_out_tag", 64'(b32.out_tag), 64'd0);
        check_eq("rst_count", 64'(cnt32), 64'd0);
        check_eq("rst_out_imm64", b64.out_imm, 64'd0);

        // Decoder vectors, 32-bit
        xfer32("i_neg1",   3'd0, 32'hFFF00093, 4'd5, 32'hFFFFFFFF, 1'b0);
        xfer32("auto_b",   3'd7, 32'hFE000EE3, 4'd1, 32'hFFFFFFFC, 1'b0);
        xfer32("auto_j",   3'd7, 32'h008000EF, 4'd2, 32'h00000008, 1'b0);
        xfer32("auto_u",   3'd7, 32'h12345037, 4'd3, 32'h12345000, 1'b0);
        xfer32("auto_bad", 3'd7, 32'h0000007F, 4'd4, 32'h00000000, 1'b1);
        xfer32("s_neg4",   3'd1, 32'hFE000E23, 4'd6, 32'hFFFFFFFC, 1'b0);
        xfer32("auto_sys", 3'd7, 32'h30200073, 4'd7, 32'h00000302, 1'b0);
        xfer32("z32",      3'd5, 32'h340FD073, 4'd8, 32'h0000001F, 1'b0);
        xfer32("shamt32",  3'd6, 32'h03F01013, 4'd9, 32'h0000001F, 1'b0);

        // Decoder vectors, 64-bit
        xfer64("auto_i64", 3'd7, 32'hFFF00093, 64'hFFFFFFFFFFFFFFFF);
        xfer64("shamt64",  3'd6, 32'h03F01013, 64'd63);
        xfer64("z64",      3'd5, 32'h340FD073, 64'd31);
        xfer64("u64",      3'd3, 32'h80000037, 64'hFFFFFFFF80000000);

        // Backpressure: third push held while full, then drained in order
        exp_q.delete(); n_pop = 0;
        b32.in_op = 3'd0; b32.in_instr = 32'h00100093; b32.out_ready = 1'b0;
        b32.in_valid = 1'b1; b32.in_tag = 4'd1; cycle32();
        b32.in_tag = 4'd2; cycle32();
        b32.in_tag = 4'd3;
        check_eq("t4_full", 64'(b32.in_ready), 64'd0);
        cycle32(); cycle32();
        b32.out_ready = 1'b1; cycle32(); cycle32();
        b32.in_valid = 1'b0; cycle32(); cycle32();
        check_eq("t4_pops", 64'(n_pop), 64'd3);

        // Steady stream across pointer wrap
        n_pop = 0; b32.out_ready = 1'b0;
        b32.in_valid = 1'b1; b32.in_tag = 4'd0; cycle32();
        b32.out_ready = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            b32.in_tag = 4'(i);
            cycle32();
            check_eq("t5_count", 64'(cnt32), 64'd1);
        end
        b32.in_valid = 1'b0; cycle32(); cycle32();
        check_eq("t5_pops", 64'(n_pop), 64'd21);

        // Flush with a full buffer, then with one entry and a live push
        b32.out_ready = 1'b0; b32.in_valid = 1'b1;
        b32.in_tag = 4'd4; cycle32();
        b32.in_tag = 4'd5; cycle32();
        b32.in_tag = 4'hF; b32.flush = 1'b1; cycle32();
        b32.flush = 1'b0; b32.in_valid = 1'b0;
        check_eq("t6_flush_valid", 64'(b32.out_valid), 64'd0);
        check_eq("t6_flush_count", 64'(cnt32), 64'd0);
        b32.in_valid = 1'b1; b32.in_tag = 4'd6; cycle32();
        b32.in_tag = 4'hE; b32.flush = 1'b1; cycle32();
        b32.flush = 1'b0; b32.in_tag = 4'd7; cycle32();
        b32.in_valid = 1'b0; b32.out_ready = 1'b1; cycle32(); cycle32();

        // Reset mid-stream
        b32.out_ready = 1'b0; b32.in_valid = 1'b1; b32.in_instr = 32'hABC00093;
        b32.in_tag = 4'd8; cycle32();
        b32.in_tag = 4'd9; cycle32();
        rst = 1'b1; b32.in_tag = 4'hD; cycle32();
        rst = 1'b0; b32.in_valid = 1'b0;
        check_eq("t6_rst_valid", 64'(b32.out_valid), 64'd0);
        check_eq("t6_rst_ready", 64'(b32.in_ready), 64'd1);
        check_eq("t6_rst_imm", 64'(b32.out_imm), 64'd0);
        check_eq("t6_rst_tag", 64'(b32.out_tag), 64'd0);
        check_eq("t6_rst_err", 64'(b32.out_err), 64'd0);
        b32.in_valid = 1'b1; b32.in_tag = 4'hA; b32.in_instr = 32'h00100093; cycle32();
        b32.in_valid = 1'b0;
        check_eq("t6_after_rst_imm", 64'(b32.out_imm), 64'd1);
        b32.out_ready = 1'b1; cycle32(); cycle32();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
